// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths, select codes, unit enum and payload type for the writeback arbiter
package wb_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int REG_W = 5;
  localparam int TAG_W = 4;
  localparam logic [2:0] WB_SEL_AU = 3'b100;
  localparam logic [2:0] WB_SEL_MUL = 3'b010;
  localparam logic [2:0] WB_SEL_LSU = 3'b001;
  localparam logic [2:0] WB_SEL_NONE = 3'b000;
  typedef enum logic [1:0] {AU, MUL, LSU} unit_e;
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0] data;
  } wb_payload_t;
  function automatic unit_e next_unit(unit_e u);
    return u == LSU ? AU : unit_e'(u + 2'd1);
  endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: execution-unit result ports and writeback output stage bundled for the arbiter
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;
  logic flush;
  logic au_valid, mul_valid, lsu_valid;
  logic [REG_W-1:0] au_rd, mul_rd, lsu_rd;
  logic [TAG_W-1:0] au_tag, mul_tag, lsu_tag;
  logic [XLEN-1:0] au_data, mul_data, lsu_data;
  logic au_grant, mul_grant, lsu_grant;
  logic wb_valid, wb_ready;
  logic [2:0] wb_select;
  logic [REG_W-1:0] wb_rd;
  logic [TAG_W-1:0] wb_tag;
  logic [XLEN-1:0] wb_data;
  modport master (
    input flush, au_valid, mul_valid, lsu_valid, au_rd, mul_rd, lsu_rd,
    input au_tag, mul_tag, lsu_tag, au_data, mul_data, lsu_data, wb_ready,
    output au_grant, mul_grant, lsu_grant, wb_valid, wb_select, wb_rd, wb_tag, wb_data
  );
  modport slave (
    output flush, au_valid, mul_valid, lsu_valid, au_rd, mul_rd, lsu_rd,
    output au_tag, mul_tag, lsu_tag, au_data, mul_data, lsu_data, wb_ready,
    input au_grant, mul_grant, lsu_grant, wb_valid, wb_select, wb_rd, wb_tag, wb_data
  );
endinterface

// File: rtl/wb_arbiter_rr_picker3.sv
// rr_picker3: three-way round-robin pick from ptr, giving a one-hot winner and the pointer after it
module rr_picker3
  import wb_arbiter_pkg::*;
(
  input  unit_e      ptr,
  input  logic [2:0] valid,
  output logic [2:0] win,
  output unit_e      ptr_nxt
);
  logic [2:0] vu;
  unit_e p1, p2, w;
  // valid is in select-code order (AU in bit 2); vu is indexed by unit
  assign vu = {valid[0], valid[1], valid[2]};
  always_comb begin
    p1 = next_unit(ptr);
    p2 = next_unit(p1);
    w = vu[ptr] ? ptr : vu[p1] ? p1 : p2;
    win = |valid ? WB_SEL_AU >> w : WB_SEL_NONE;
    ptr_nxt = |valid ? next_unit(w) : ptr;
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter sharing the writeback port among AU, MUL and LSU with a registered output stage
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input logic clk,
  input logic rst_n,
  wb_arbiter_if.master bus
);
  unit_e ptr, ptr_nxt;
  logic [2:0] valid, win, sel_q;
  logic load, held;
  wb_payload_t pay, pay_q;
  assign valid = {bus.au_valid, bus.mul_valid, bus.lsu_valid};
  // rst_n gates load so no grant is visible while reset is asserted
  assign load = rst_n && !bus.flush && (!held || bus.wb_ready) && |valid;
  rr_picker3 picker (.ptr(ptr), .valid(valid), .win(win), .ptr_nxt(ptr_nxt));
  assign {bus.au_grant, bus.mul_grant, bus.lsu_grant} = load ? win : WB_SEL_NONE;
  always_comb
    pay = win[2] ? {bus.au_rd, bus.au_tag, bus.au_data}
        : win[1] ? {bus.mul_rd, bus.mul_tag, bus.mul_data}
        : {bus.lsu_rd, bus.lsu_tag, bus.lsu_data};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      held <= 1'b0;
      sel_q <= WB_SEL_NONE;
      pay_q <= '0;
      ptr <= AU;
    end else if (load) begin
      held <= 1'b1;
      sel_q <= win;
      pay_q <= pay;
      ptr <= ptr_nxt;
    end else if (bus.flush || bus.wb_ready) begin
      held <= 1'b0;
      sel_q <= WB_SEL_NONE;
    end
  assign bus.wb_valid = held;
  assign bus.wb_select = sel_q;
  assign bus.wb_rd = pay_q.rd;
  assign bus.wb_tag = pay_q.tag;
  assign bus.wb_data = pay_q.data;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and random checks of wb_arbiter against a round-robin reference model and scoreboard
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  logic clk = 0, rst_n = 1, ready = 0, flush = 0;
  logic uv[3];
  wb_payload_t up[3];
  always #5 clk = ~clk;
  wb_arbiter_if bus();
  wb_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  assign bus.au_valid = uv[0];
  assign bus.mul_valid = uv[1];
  assign bus.lsu_valid = uv[2];
  assign bus.au_rd = up[0].rd;
  assign bus.mul_rd = up[1].rd;
  assign bus.lsu_rd = up[2].rd;
  assign bus.au_tag = up[0].tag;
  assign bus.mul_tag = up[1].tag;
  assign bus.lsu_tag = up[2].tag;
  assign bus.au_data = up[0].data;
  assign bus.mul_data = up[1].data;
  assign bus.lsu_data = up[2].data;
  assign bus.wb_ready = ready;
  assign bus.flush = flush;

  int n_chk = 0, n_pass = 0;
  logic m_valid = 0;
  int m_sel = 0, m_ptr = 0, g, gm;
  int w[3];
  wb_payload_t m_pay, got;
  wb_payload_t sb[$];
  logic [2:0] dg;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [2:0] code(int u);
    return u < 0 ? 3'b000 : 3'b100 >> u;
  endfunction

  // reference rule: no grant under reset, flush or a stalled full stage; else first valid from ptr
  function automatic int exp_win();
    if (!rst_n || flush || (m_valid && !ready)) return -1;
    for (int k = 0; k < 3; k++)
      if (uv[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_valid <= 0;
      m_ptr <= 0;
      sb.delete();
    end else begin
      gm = exp_win();
      if (m_valid && flush && sb.size() != 0) void'(sb.pop_front());
      if (gm >= 0) begin
        m_valid <= 1;
        m_sel <= gm;
        m_pay <= up[gm];
        m_ptr <= (gm + 1) % 3;
        sb.push_back(up[gm]);
      end else if (flush || ready) m_valid <= 0;
    end

  always @(negedge clk)
    if (!rst_n) w = '{0, 0, 0};
    else begin
      g = exp_win();
      dg = {bus.au_grant, bus.mul_grant, bus.lsu_grant};
      chk("grant", dg, code(g));
      chk("wb_valid", bus.wb_valid, m_valid);
      chk("wb_select", bus.wb_select, m_valid ? code(m_sel) : 3'b000);
      chk("sel_onehot0", $onehot0(bus.wb_select), 1);
      if (m_valid) begin
        chk("wb_rd", bus.wb_rd, m_pay.rd);
        chk("wb_tag", bus.wb_tag, m_pay.tag);
        chk("wb_data", bus.wb_data, m_pay.data);
      end
      if (bus.wb_valid && ready && !flush) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          got = sb.pop_front();
          chk("sb_payload", {bus.wb_rd, bus.wb_tag, bus.wb_data}, got);
        end
      end
      if (|dg)
        for (int u = 0; u < 3; u++)
          if (!uv[u] || dg[2-u]) w[u] = 0;
          else begin
            w[u]++;
            chk("fairness", w[u] <= 2, 1);
          end
    end

  task automatic rnd(int u);
    up[u].rd = 5'($urandom);
    up[u].tag = 4'($urandom);
    up[u].data = $urandom;
  endtask

  // mode 0: granted units go idle; 1: granted units refill; 2: random producers
  task automatic tick(int mode);
    logic [2:0] gr;
    #1 gr = {bus.au_grant, bus.mul_grant, bus.lsu_grant};
    @(posedge clk);
    #2;
    for (int u = 0; u < 3; u++)
      if (mode == 0 && gr[2-u]) uv[u] = 0;
      else if (mode == 1 && gr[2-u]) rnd(u);
      else if (mode == 2 && (gr[2-u] || !uv[u])) begin
        uv[u] = 1'($urandom_range(0, 1));
        rnd(u);
      end
  endtask

  logic [2:0] rr_seq[6] = '{3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b100};

  initial begin
    uv = '{0, 0, 0};
    for (int u = 0; u < 3; u++) up[u] = '0;
    #1 rst_n = 0;
    #2;
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_select", bus.wb_select, 3'b000);
    chk("rst_wb_payload", {bus.wb_rd, bus.wb_tag, bus.wb_data}, 0);
    up[0] = '{rd: 5'd5, tag: 4'd3, data: 32'h1234};
    uv[0] = 1;
    ready = 1;
    #1 chk("rst_grants", {bus.au_grant, bus.mul_grant, bus.lsu_grant}, 3'b000);
    #8 rst_n = 1;
    #1 chk("first_au_grant", {bus.au_grant, bus.mul_grant, bus.lsu_grant}, 3'b100);
    tick(0);
    chk("first_wb_valid", bus.wb_valid, 1);
    chk("first_wb_select", bus.wb_select, 3'b100);
    chk("first_wb_rd", bus.wb_rd, 5);
    chk("first_wb_tag", bus.wb_tag, 3);
    chk("first_wb_data", bus.wb_data, 32'h1234);
    for (int u = 0; u < 3; u++) begin
      rnd(u);
      uv[u] = 1;
    end
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_grant", {bus.au_grant, bus.mul_grant, bus.lsu_grant}, rr_seq[i]);
      if (i > 0) chk("rr_select", bus.wb_select, rr_seq[i-1]);
      tick(1);
    end
    chk("rr_select_last", bus.wb_select, 3'b100);
    repeat (3) tick(0);
    up[1] = '{rd: 5'd9, tag: 4'd7, data: 32'hCAFE};
    uv[1] = 1;
    #1 chk("mul_grant", {bus.au_grant, bus.mul_grant, bus.lsu_grant}, 3'b010);
    tick(0);
    ready = 0;
    up[2] = '{rd: 5'd1, tag: 4'd2, data: 32'h5A5A};
    uv[2] = 1;
    repeat (3) begin
      #1 chk("stall_grants", {bus.au_grant, bus.mul_grant, bus.lsu_grant}, 3'b000);
      chk("stall_select", bus.wb_select, 3'b010);
      chk("stall_data", bus.wb_data, 32'hCAFE);
      tick(0);
    end
    ready = 1;
    #1 chk("unstall_lsu_grant", {bus.au_grant, bus.mul_grant, bus.lsu_grant}, 3'b001);
    tick(0);
    chk("unstall_select", bus.wb_select, 3'b001);
    chk("unstall_data", bus.wb_data, 32'h5A5A);
    ready = 0;
    flush = 1;
    rnd(0);
    rnd(1);
    uv[0] = 1;
    uv[1] = 1;
    #1 chk("flush_grants", {bus.au_grant, bus.mul_grant, bus.lsu_grant}, 3'b000);
    tick(0);
    chk("flush_wb_valid", bus.wb_valid, 0);
    chk("flush_select", bus.wb_select, 3'b000);
    flush = 0;
    ready = 1;
    #1 chk("flush_ptr_kept", {bus.au_grant, bus.mul_grant, bus.lsu_grant}, 3'b100);
    tick(0);
    tick(0);
    for (int u = 0; u < 3; u++) begin
      rnd(u);
      uv[u] = 1;
    end
    tick(1);
    tick(1);
    #2 rst_n = 0;
    #1;
    chk("async_wb_valid", bus.wb_valid, 0);
    chk("async_select", bus.wb_select, 3'b000);
    chk("async_grants", {bus.au_grant, bus.mul_grant, bus.lsu_grant}, 3'b000);
    @(posedge clk);
    #3 rst_n = 1;
    #1 chk("post_reset_au", {bus.au_grant, bus.mul_grant, bus.lsu_grant}, 3'b100);
    tick(1);
    for (int i = 0; i < 10000; i++) begin
      ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 31) == 0;
      tick(2);
    end
    flush = 0;
    @(negedge clk);
    #1 $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
